// File: rtl/uart_debug_loader.sv
// UART command-frame loader: receives SYNC/addr/data/csum frames and
// issues one 32-bit bus write per frame, answering with an ACK/NAK byte.
module uart_debug_loader #(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned UART_BPS  = 19200,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter logic [7:0]  ACK_BYTE  = 8'h06,
  parameter logic [7:0]  NAK_BYTE  = 8'h15,
  parameter int unsigned GAP_BITS  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        bus_req_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  output logic        halt_o,
  output logic        busy_o
);

  localparam int unsigned BIT_CYC = CLK_FREQ / UART_BPS;
  localparam int unsigned GAP_CYC = GAP_BITS * BIT_CYC;
  localparam int unsigned CW = $clog2(BIT_CYC + 1);
  localparam int unsigned GW = $clog2(GAP_CYC + 1);

  localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] BIT_MID  = CW'(BIT_CYC / 2 - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

  typedef enum logic [1:0] {
    R_IDLE, R_START, R_DATA, R_STOP
  } rx_state_e;

  typedef enum logic [2:0] {
    F_SYNC, F_ADDR, F_DATA, F_CSUM, F_WRITE, F_RESP
  } f_state_e;

  // RX path
  logic          rx_s1_q, rx_s1_d;
  logic          rx_s2_q, rx_s2_d;
  logic          rx_prev_q, rx_prev_d;
  rx_state_e     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic          rx_vld_q, rx_vld_d;
  logic          rx_ferr_q, rx_ferr_d;

  // frame path
  f_state_e      f_state_q, f_state_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [31:0]   addr_sh_q, addr_sh_d;
  logic [31:0]   data_sh_q, data_sh_d;
  logic [7:0]    csum_q, csum_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          bus_req_q, bus_req_d;
  logic [31:0]   bus_addr_q, bus_addr_d;
  logic [31:0]   bus_wdata_q, bus_wdata_d;

  // TX path
  logic          tx_busy_q, tx_busy_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic [8:0]    tx_sh_q, tx_sh_d;
  logic          uart_tx_q, uart_tx_d;

  logic          tx_load;
  logic [7:0]    tx_byte;
  logic          tx_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= R_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_sh_q     <= '0;
      rx_vld_q    <= 1'b0;
      rx_ferr_q   <= 1'b0;
      f_state_q   <= F_SYNC;
      byte_cnt_q  <= '0;
      addr_sh_q   <= '0;
      data_sh_q   <= '0;
      csum_q      <= '0;
      gap_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      tx_busy_q   <= 1'b0;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_sh_q     <= '1;
      uart_tx_q   <= 1'b1;
    end else begin
      rx_s1_q     <= rx_s1_d;
      rx_s2_q     <= rx_s2_d;
      rx_prev_q   <= rx_prev_d;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_sh_q     <= rx_sh_d;
      rx_vld_q    <= rx_vld_d;
      rx_ferr_q   <= rx_ferr_d;
      f_state_q   <= f_state_d;
      byte_cnt_q  <= byte_cnt_d;
      addr_sh_q   <= addr_sh_d;
      data_sh_q   <= data_sh_d;
      csum_q      <= csum_d;
      gap_q       <= gap_d;
      bus_req_q   <= bus_req_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      tx_busy_q   <= tx_busy_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_sh_q     <= tx_sh_d;
      uart_tx_q   <= uart_tx_d;
    end
  end

  // edge-detect cycle counts as cycle 0 of the start bit
  always_comb begin
    rx_s1_d    = uart_rx;
    rx_s2_d    = rx_s1_q;
    rx_prev_d  = rx_s2_q;
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_vld_d   = 1'b0;
    rx_ferr_d  = 1'b0;
    unique case (rx_state_q)
      R_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_state_d = R_START;
          rx_cnt_d   = CW'(1);
        end
      end
      R_START: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = R_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      R_DATA: begin
        if (rx_cnt_q == BIT_MID) begin
          rx_sh_d = {rx_s2_q, rx_sh_q[7:1]};
        end
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d = '0;
          if (rx_bit_q == 3'd7) begin
            rx_state_d = R_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      R_STOP: begin
        if (rx_cnt_q == BIT_MID) begin
          rx_cnt_d   = '0;
          rx_state_d = R_IDLE;
          rx_vld_d   = rx_s2_q;
          rx_ferr_d  = !rx_s2_q;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      default: rx_state_d = R_IDLE;
    endcase
  end

  assign tx_done = tx_busy_q && (tx_bit_q == 4'd9) &&
                   (tx_cnt_q == BIT_LAST);

  always_comb begin
    f_state_d   = f_state_q;
    byte_cnt_d  = byte_cnt_q;
    addr_sh_d   = addr_sh_q;
    data_sh_d   = data_sh_q;
    csum_d      = csum_q;
    gap_d       = '0;
    bus_req_d   = bus_req_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    tx_load     = 1'b0;
    tx_byte     = NAK_BYTE;
    unique case (f_state_q)
      F_SYNC: begin
        if (rx_vld_q && (rx_sh_q == SYNC_BYTE)) begin
          f_state_d  = F_ADDR;
          byte_cnt_d = '0;
          csum_d     = '0;
        end
      end
      F_ADDR, F_DATA, F_CSUM: begin
        if (rx_ferr_q) begin
          f_state_d = F_RESP;
          tx_load   = 1'b1;
        end else if (rx_vld_q) begin
          unique case (1'b1)
            f_state_q == F_ADDR: begin
              addr_sh_d  = {rx_sh_q, addr_sh_q[31:8]};
              csum_d     = csum_q ^ rx_sh_q;
              byte_cnt_d = byte_cnt_q + 2'd1;
              if (byte_cnt_q == 2'd3) f_state_d = F_DATA;
            end
            f_state_q == F_DATA: begin
              data_sh_d  = {rx_sh_q, data_sh_q[31:8]};
              csum_d     = csum_q ^ rx_sh_q;
              byte_cnt_d = byte_cnt_q + 2'd1;
              if (byte_cnt_q == 2'd3) f_state_d = F_CSUM;
            end
            default: begin
              if (rx_sh_q == csum_q) begin
                bus_addr_d  = addr_sh_q;
                bus_wdata_d = data_sh_q;
                bus_req_d   = 1'b1;
                f_state_d   = F_WRITE;
              end else begin
                f_state_d = F_RESP;
                tx_load   = 1'b1;
              end
            end
          endcase
        end else if (gap_q == GAP_LAST) begin
          f_state_d = F_SYNC;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      F_WRITE: begin
        if (bus_req_q && bus_ack_i) begin
          bus_req_d = 1'b0;
          f_state_d = F_RESP;
          tx_load   = 1'b1;
          tx_byte   = ACK_BYTE;
        end
      end
      F_RESP: begin
        if (tx_done) f_state_d = F_SYNC;
      end
      default: f_state_d = F_SYNC;
    endcase
  end

  // bit index: 0 start, 1..8 data, 9 stop
  always_comb begin
    tx_busy_d = tx_busy_q;
    tx_cnt_d  = tx_cnt_q;
    tx_bit_d  = tx_bit_q;
    tx_sh_d   = tx_sh_q;
    uart_tx_d = uart_tx_q;
    if (tx_load) begin
      tx_busy_d = 1'b1;
      tx_cnt_d  = '0;
      tx_bit_d  = '0;
      tx_sh_d   = {1'b1, tx_byte};
      uart_tx_d = 1'b0;
    end else if (tx_busy_q) begin
      if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d = '0;
        if (tx_bit_q == 4'd9) begin
          tx_busy_d = 1'b0;
          uart_tx_d = 1'b1;
        end else begin
          uart_tx_d = tx_sh_q[0];
          tx_sh_d   = {1'b1, tx_sh_q[8:1]};
          tx_bit_d  = tx_bit_q + 4'd1;
        end
      end else begin
        tx_cnt_d = tx_cnt_q + CW'(1);
      end
    end
  end

  assign uart_tx     = uart_tx_q;
  assign bus_req_o   = bus_req_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;
  assign halt_o      = (f_state_q != F_SYNC);
  assign busy_o      = (f_state_q != F_SYNC);

endmodule

// File: tb/tb_uart_debug_loader.sv
// Directed bench for uart_debug_loader: host-side UART driver, reply
// decoder and a bus slave with programmable ack latency.
module tb_uart_debug_loader;

  localparam int BIT = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        uart_rx;
  logic        uart_tx;
  logic        bus_req_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ack_i;
  logic        halt_o;
  logic        busy_o;

  always #5 clk = ~clk;

  uart_debug_loader #(
    .CLK_FREQ(1000000),
    .UART_BPS(100000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .uart_rx    (uart_rx),
    .uart_tx    (uart_tx),
    .bus_req_o  (bus_req_o),
    .bus_addr_o (bus_addr_o),
    .bus_wdata_o(bus_wdata_o),
    .bus_ack_i  (bus_ack_i),
    .halt_o     (halt_o),
    .busy_o     (busy_o)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reply decoder
  logic [7:0] rxq[$];
  logic [7:0] mb;
  logic       mon_stop;
  logic       halt_at_stop;
  bit         mon_en = 1'b0;

  initial forever begin
    @(negedge uart_tx);
    if (mon_en) begin
      repeat (BIT/2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (BIT) @(negedge clk);
        mb[i] = uart_tx;
      end
      repeat (BIT) @(negedge clk);
      mon_stop     = uart_tx;
      halt_at_stop = halt_o;
      rxq.push_back(mb);
    end
  end

  // bus slave
  bit          ack_tie = 1'b0;
  int          ack_dly = 3;
  int          req_hi = 0;
  int          req_pulses = 0;
  int          req_wait = 0;
  logic        req_prev = 1'b0;
  logic [31:0] cap_addr = '0;
  logic [31:0] cap_data = '0;

  initial begin
    bus_ack_i = 1'b0;
    forever begin
      @(negedge clk);
      if (bus_req_o === 1'b1) begin
        req_hi++;
        if (!req_prev) req_pulses++;
        cap_addr = bus_addr_o;
        cap_data = bus_wdata_o;
      end
      req_prev = (bus_req_o === 1'b1);
      bus_ack_i = ack_tie || (req_prev && req_wait >= ack_dly);
      req_wait  = req_prev ? req_wait + 1 : 0;
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    uart_rx = stop;
    repeat (BIT) @(negedge clk);
    uart_rx = 1'b1;
    if (!stop) repeat (BIT) @(negedge clk);
  endtask

  task automatic send_frame(input logic [31:0] a, input logic [31:0] d,
                            input logic [7:0] cs);
    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8], 1'b1);
    for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8], 1'b1);
    send_byte(cs, 1'b1);
  endtask

  task automatic wait_reply(input string tag, input logic [7:0] exp);
    int t;
    t = 0;
    while (rxq.size() == 0 && t < 600) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_reply_cnt"}, rxq.size(), 1);
    if (rxq.size() != 0) begin
      chk({tag, "_reply"}, rxq.pop_front(), exp);
      chk({tag, "_stop"}, mon_stop, 1'b1);
      chk({tag, "_halt_tx"}, halt_at_stop, 1'b1);
    end
    t = 0;
    while (busy_o && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_busy_end"}, busy_o, 1'b0);
    chk({tag, "_halt_end"}, halt_o, 1'b0);
  endtask

  task automatic clr_bus();
    req_hi     = 0;
    req_pulses = 0;
  endtask

  initial begin
    int t;
    rst     = 1'b1;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx", uart_tx, 1'b1);
    chk("rst_req", bus_req_o, 1'b0);
    chk("rst_addr", bus_addr_o, 32'h0);
    chk("rst_wdata", bus_wdata_o, 32'h0);
    chk("rst_halt", halt_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (5) @(negedge clk);

    // 1: good frame, ack after 3 cycles of req
    clr_bus();
    send_frame(32'h0000_1000, 32'hDEAD_BEEF, 8'h32);
    wait_reply("t1", 8'h06);
    chk("t1_pulses", req_pulses, 1);
    chk("t1_req_cyc", req_hi, 4);
    chk("t1_addr", cap_addr, 32'h0000_1000);
    chk("t1_wdata", cap_data, 32'hDEAD_BEEF);

    // 2: bad checksum
    clr_bus();
    send_frame(32'h0000_1000, 32'hDEAD_BEEF, 8'hCD);
    wait_reply("t2", 8'h15);
    chk("t2_pulses", req_pulses, 0);

    // 3: junk before sync
    clr_bus();
    send_byte(8'h55, 1'b1);
    send_byte(8'h00, 1'b1);
    chk("t3_busy_junk", busy_o, 1'b0);
    send_frame(32'h0000_0004, 32'h1234_5678, 8'h0C);
    wait_reply("t3", 8'h06);
    chk("t3_pulses", req_pulses, 1);
    chk("t3_addr", cap_addr, 32'h0000_0004);
    chk("t3_wdata", cap_data, 32'h1234_5678);

    // 4: inter-byte timeout
    clr_bus();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    chk("t4_busy_mid", busy_o, 1'b1);
    repeat (200) @(negedge clk);
    chk("t4_busy_to", busy_o, 1'b0);
    chk("t4_halt_to", halt_o, 1'b0);
    chk("t4_no_reply", rxq.size(), 0);
    chk("t4_no_req", req_pulses, 0);
    send_frame(32'h0000_0020, 32'h0000_0001, 8'h21);
    wait_reply("t4", 8'h06);
    chk("t4_addr", cap_addr, 32'h0000_0020);
    chk("t4_wdata", cap_data, 32'h0000_0001);

    // 5a: zero-wait ack
    clr_bus();
    ack_tie = 1'b1;
    send_frame(32'h0000_0100, 32'hA5A5_A5A5, 8'h01);
    wait_reply("t5a", 8'h06);
    chk("t5a_pulses", req_pulses, 1);
    chk("t5a_req_cyc", req_hi, 1);
    chk("t5a_wdata", cap_data, 32'hA5A5_A5A5);

    // 5b: reset while the write is pending
    ack_tie = 1'b0;
    ack_dly = 100000;
    clr_bus();
    send_frame(32'h0000_0200, 32'hFFFF_FFFF, 8'h02);
    t = 0;
    while (bus_req_o !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("t5b_req_seen", bus_req_o, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5b_req_rst", bus_req_o, 1'b0);
    chk("t5b_tx_rst", uart_tx, 1'b1);
    chk("t5b_busy_rst", busy_o, 1'b0);
    chk("t5b_halt_rst", halt_o, 1'b0);
    repeat (150) @(negedge clk);
    chk("t5b_no_reply", rxq.size(), 0);
    chk("t5b_req_idle", bus_req_o, 1'b0);
    ack_dly = 3;

    // 6: framing error on D2
    clr_bus();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b0);
    wait_reply("t6", 8'h15);
    chk("t6_pulses", req_pulses, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
